// File: rtl/puf_eval_pkg.sv
// Shared types and helpers for the dual-mode (RO / arbiter) PUF measurement engine.
package puf_eval_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN,
      ST_SAMPLE,
      ST_NEXT,
      ST_DONE
   } state_t;

   localparam logic MODE_RO  = 1'b0;
   localparam logic MODE_ARB = 1'b1;

   // Widest challenge the rotation helper handles; callers cast down to N.
   localparam int ROT_MAX = 1024;

   function automatic int vote_thresh(input int rep);
      return rep / 2;
   endfunction

   // Rotate the low n bits of v left by k (k < n); bits at and above n come back zero.
   function automatic logic [ROT_MAX-1:0] rotl(input logic [ROT_MAX-1:0] v, input int n, input int k);
      logic [ROT_MAX-1:0] mask;
      mask = ({{(ROT_MAX-1){1'b0}}, 1'b1} << n) - 1'b1;
      return ((v << k) | (v >> (n - k))) & mask;
   endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Counts synchronised rising edges of an asynchronous chain tail; saturates instead of wrapping.
module puf_edge_counter
#(
   parameter int CW = 16
)
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_osc,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt
);

   // [0],[1] are the synchroniser, [2] holds the previous synced value for edge detect
   logic [2:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          w_rise;

   assign w_rise = r_sync[1] & ~r_sync[2];
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[1:0], i_osc};
         if (i_clr)
            r_cnt <= '0;
         else if (i_en && w_rise && (r_cnt != {CW{1'b1}}))
            r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/puf_dual_eval.sv
// Measurement engine for the demux/mux delay-chain PUF: RO count compare or arbiter sample,
// majority-voted per response bit, returned over a valid/ready handshake.
module puf_dual_eval
   import puf_eval_pkg::*;
#(
   parameter int N      = 128,
   parameter int CW     = 16,
   parameter int WIN    = 1024,
   parameter int SETTLE = 8,
   parameter int REP    = 5,
   parameter int RB     = 8
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic [N-1:0]  challenge,
   output logic          ready,
   output logic [N-1:0]  sel,
   output logic          chain_en,
   input  logic          osc_a,
   input  logic          osc_b,
   input  logic          arb_in,
   output logic [RB-1:0] resp,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic          tie
);

   localparam int TW = $clog2(((WIN > SETTLE) ? WIN : SETTLE) + 1);
   localparam int RW = $clog2(REP + 1);
   localparam int KW = (RB > 1) ? $clog2(RB) : 1;

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_tmr;
   logic [RW-1:0] r_rep, r_votes;
   logic [KW-1:0] r_k, w_rot_k;
   logic          r_mode, r_tie;
   logic [N-1:0]  r_chal, r_sel, w_rot;
   logic [RB-1:0] r_resp;
   logic [1:0]    r_arb_sync;
   logic [CW-1:0] w_cnt_a, w_cnt_b;
   logic          w_bit, w_last_rep, w_last_bit, w_maj;

   puf_edge_counter #(.CW(CW)) u_cnt_a (
      .i_clk(clk), .i_rst_n(reset), .i_osc(osc_a),
      .i_clr(r_state == ST_SETTLE), .i_en(r_state == ST_RUN), .o_cnt(w_cnt_a)
   );

   puf_edge_counter #(.CW(CW)) u_cnt_b (
      .i_clk(clk), .i_rst_n(reset), .i_osc(osc_b),
      .i_clr(r_state == ST_SETTLE), .i_en(r_state == ST_RUN), .o_cnt(w_cnt_b)
   );

   assign w_bit      = (r_mode == MODE_ARB) ? r_arb_sync[1] : (w_cnt_a > w_cnt_b);
   assign w_last_rep = (r_rep == RW'(REP - 1));
   assign w_last_bit = (r_k == KW'(RB - 1));
   assign w_maj      = (r_votes > RW'(vote_thresh(REP)));
   // NEXT loads the challenge for the following bit, LOAD the one for bit 0
   assign w_rot_k    = (r_state == ST_NEXT) ? (r_k + KW'(1)) : r_k;
   assign w_rot      = N'(rotl(ROT_MAX'(r_chal), N, int'(w_rot_k)));

   assign sel  = r_sel;
   assign resp = r_resp;
   assign tie  = r_tie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      chain_en    = 1'b0;
      resp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) w_state_nxt = ST_LOAD;
         end
         ST_LOAD:   w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_tmr == TW'(SETTLE - 1)) w_state_nxt = ST_RUN;
         ST_RUN: begin
            chain_en = 1'b1;
            if (r_tmr == TW'(WIN - 1)) w_state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: w_state_nxt = w_last_rep ? ST_NEXT : ST_SETTLE;
         ST_NEXT:   w_state_nxt = w_last_bit ? ST_DONE : ST_SETTLE;
         ST_DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) w_state_nxt = ST_IDLE;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmr      <= '0;
         r_rep      <= '0;
         r_votes    <= '0;
         r_k        <= '0;
         r_mode     <= MODE_RO;
         r_tie      <= 1'b0;
         r_chal     <= '0;
         r_sel      <= '0;
         r_resp     <= '0;
         r_arb_sync <= '0;
      end else begin
         r_arb_sync <= {r_arb_sync[0], arb_in};
         if (w_state_nxt != r_state)
            r_tmr <= '0;
         else if ((r_state == ST_SETTLE) || (r_state == ST_RUN))
            r_tmr <= r_tmr + TW'(1);
         case (r_state)
            ST_IDLE: if (start) begin
               r_chal  <= challenge;
               r_mode  <= mode;
               r_resp  <= '0;
               r_tie   <= 1'b0;
               r_k     <= '0;
               r_votes <= '0;
               r_rep   <= '0;
            end
            ST_LOAD: r_sel <= w_rot;
            ST_SAMPLE: begin
               r_votes <= r_votes + RW'(w_bit);
               r_rep   <= r_rep + RW'(1);
               if ((r_mode == MODE_RO) && (w_cnt_a == w_cnt_b)) r_tie <= 1'b1;
            end
            ST_NEXT: begin
               for (int i = 0; i < RB; i++)
                  if (r_k == KW'(i)) r_resp[i] <= w_maj;
               r_votes <= '0;
               r_rep   <= '0;
               if (!w_last_bit) begin
                  r_k   <= r_k + KW'(1);
                  r_sel <= w_rot;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_dual_eval.sv
// Randomised self-checking bench for puf_dual_eval with a behavioural vote/rotation model.
module tb_puf_dual_eval;

   localparam int N = 8, CW = 4, WIN = 16, SETTLE = 4, REP = 3, RB = 4;
   localparam int LAT = 1 + RB * (REP * (SETTLE + WIN + 1) + 1) + 1;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, arb_in = 1'b0, resp_ready = 1'b0;
   logic [N-1:0] challenge = '0;
   logic osc_t2 = 1'b0, osc_t4 = 1'b0, osc_a, osc_b;
   int   ro_pat = 0;
   logic ready, chain_en, resp_valid, tie;
   logic [N-1:0] sel;
   logic [RB-1:0] resp;
   logic ready2, chain_en2, resp_valid2, tie2;
   logic [N-1:0] sel2;
   logic [RB-1:0] resp2;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   // Free-running tails: osc_t2 at clk/2, osc_t4 at clk/4, offset from the clock edges
   initial begin
      #3;
      forever begin
         #10;
         osc_t2 = ~osc_t2;
         if (!osc_t2) osc_t4 = ~osc_t4;
      end
   end

   assign osc_a = osc_t2;
   assign osc_b = (ro_pat == 2) ? osc_t2 : (ro_pat == 1) ? osc_t4 : 1'b0;

   puf_dual_eval #(.N(N), .CW(CW), .WIN(WIN), .SETTLE(SETTLE), .REP(REP), .RB(RB)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .challenge(challenge),
      .ready(ready), .sel(sel), .chain_en(chain_en), .osc_a(osc_a), .osc_b(osc_b),
      .arb_in(arb_in), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready), .tie(tie)
   );

   // Narrow counters, silent b tail: a must saturate at 3 and still win every compare
   puf_dual_eval #(.N(N), .CW(2), .WIN(WIN), .SETTLE(SETTLE), .REP(REP), .RB(RB)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .challenge(challenge),
      .ready(ready2), .sel(sel2), .chain_en(chain_en2), .osc_a(osc_a), .osc_b(1'b0),
      .arb_in(arb_in), .resp(resp2), .resp_valid(resp_valid2), .resp_ready(resp_ready), .tie(tie2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RB-1:0] maj(input logic [RB*REP-1:0] a);
      logic [RB-1:0] r;
      r = '0;
      for (int k = 0; k < RB; k++) begin
         int ones;
         ones = 0;
         for (int j = 0; j < REP; j++) ones += int'(a[k*REP+j]);
         r[k] = (ones * 2 > REP);
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rot_model(input logic [N-1:0] c, input int k);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[(i + k) % N] = c[i];
      return r;
   endfunction

   // Called at a negedge with the engine idle; returns at a negedge with it idle again.
   task automatic run_req(input logic m, input logic [N-1:0] ch, input logic [RB*REP-1:0] arb,
                          input logic [RB-1:0] exp_r, input logic exp_t, input bit hold);
      int lat, ev;
      logic prev;
      chk("ready_pre", ready, 1);
      start = 1'b1; mode = m; challenge = ch; arb_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("ready_fall", ready, 0);
      lat = 1; ev = 0; prev = 1'b0;
      while (!resp_valid && lat < LAT + 50) begin
         if (chain_en && !prev) begin
            if (ev % REP == 0) chk("sel", sel, rot_model(ch, ev / REP));
            if (ev < RB * REP) arb_in = arb[ev];
            ev++;
         end
         prev = chain_en;
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, LAT);
      chk("evals", ev, RB * REP);
      chk("valid", resp_valid, 1);
      chk("resp", resp, exp_r);
      chk("tie", tie, exp_t);
      chk("resp_sat", resp2, m ? exp_r : {RB{1'b1}});
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            start = 1'b1; challenge = N'($urandom);
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_resp", resp, exp_r);
            chk("hold_ready", ready, 0);
         end
         start = 1'b0;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("ready_ret", ready, 1);
      chk("valid_drop", resp_valid, 0);
   endtask

   initial begin
      logic [N-1:0] ch;
      logic [RB*REP-1:0] arb;
      int n;

      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_sel", sel, 0);
      chk("rst_en", chain_en, 0);
      chk("rst_resp", resp, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_tie", tie, 0);
      reset = 1'b1;
      @(negedge clk);

      ro_pat = 1;
      run_req(1'b0, 8'hA5, '0, 4'hF, 1'b0, 1'b0);
      ro_pat = 2;
      run_req(1'b0, N'($urandom), '0, 4'h0, 1'b1, 1'b0);

      // Arbiter votes per bit: 1,0,1 / 0,0,1 / 1,1,1 / 0,1,0; held in DONE, next start same cycle
      run_req(1'b1, 8'h69, 12'h5E5, 4'b0101, 1'b0, 1'b1);
      for (int t = 0; t < 4; t++) begin
         ch = N'($urandom); arb = (RB*REP)'($urandom);
         run_req(1'b1, ch, arb, maj(arb), 1'b0, 1'b0);
      end
      for (int t = 0; t < 2; t++) begin
         ro_pat = int'($urandom_range(1, 2));
         run_req(1'b0, N'($urandom), '0, (ro_pat == 1) ? 4'hF : 4'h0, ro_pat == 2, 1'b0);
      end

      // Reset during the second RUN, after the first tie has been recorded
      ro_pat = 2;
      start = 1'b1; mode = 1'b0; challenge = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!chain_en && n < 100) begin @(negedge clk); n++; end
      while (chain_en && n < 100) begin @(negedge clk); n++; end
      while (!chain_en && n < 100) begin @(negedge clk); n++; end
      chk("reach_run", chain_en, 1);
      chk("tie_before_rst", tie, 1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_ready", ready, 1);
      chk("mid_sel", sel, 0);
      chk("mid_en", chain_en, 0);
      chk("mid_resp", resp, 0);
      chk("mid_valid", resp_valid, 0);
      chk("mid_tie", tie, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", ready, 1);
      chk("post_rst_valid", resp_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
